// File: rtl/pst_eval_engine_pkg.sv
// Shared definitions for the piece-square-table evaluator: piece codes,
// board geometry and the scan FSM state type.
package pst_eval_engine_pkg;

  localparam int unsigned NUM_SQ    = 64;
  localparam int unsigned SQ_W      = 6;
  localparam int unsigned PIECE_W   = 4;
  localparam int unsigned TYPE_W    = 3;
  localparam int unsigned BOARD_W   = NUM_SQ * PIECE_W;
  localparam int unsigned COLOR_BIT = 3;

  localparam logic [TYPE_W-1:0] EMPTY  = 3'd0;
  localparam logic [TYPE_W-1:0] PAWN   = 3'd1;
  localparam logic [TYPE_W-1:0] KNIGHT = 3'd2;
  localparam logic [TYPE_W-1:0] BISHOP = 3'd3;
  localparam logic [TYPE_W-1:0] ROOK   = 3'd4;
  localparam logic [TYPE_W-1:0] QUEEN  = 3'd5;
  localparam logic [TYPE_W-1:0] KING   = 3'd6;

  // XOR with this flips the rank of a square index (a1 <-> a8)
  localparam logic [SQ_W-1:0] SQ_MIRROR = 6'd56;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pst_eval_engine_if.sv
// Host-side bus of the PST evaluator: board/start/result plus the table write port.
interface pst_eval_engine_if
  import pst_eval_engine_pkg::*;
#(
  parameter int unsigned VAL_W   = 6,
  parameter int unsigned SCORE_W = 16
);

  logic [BOARD_W-1:0]        board;
  logic                      start;
  logic                      busy;
  logic                      done;
  logic signed [SCORE_W-1:0] score;
  logic                      wr_en;
  logic [TYPE_W-1:0]         wr_type;
  logic [SQ_W-1:0]           wr_sq;
  logic signed [VAL_W-1:0]   wr_data;

  modport master (
    output board, start, wr_en, wr_type, wr_sq, wr_data,
    input  busy, done, score
  );

  modport slave (
    input  board, start, wr_en, wr_type, wr_sq, wr_data,
    output busy, done, score
  );

endinterface

// File: rtl/pst_square_term.sv
// Per-square contribution: picks the table row/square to read (rank mirror for
// black) and turns the read entry into a sign-extended, colour-signed term.
module pst_square_term
  import pst_eval_engine_pkg::*;
#(
  parameter int unsigned NUM_TYPES = 6,
  parameter int unsigned VAL_W     = 6,
  parameter int unsigned SCORE_W   = 16
) (
  input  logic [PIECE_W-1:0]        piece,
  input  logic [SQ_W-1:0]           sq,
  output logic [TYPE_W-1:0]         rd_type_c,
  output logic [SQ_W-1:0]           rd_sq_c,
  input  logic signed [VAL_W-1:0]   rd_val,
  output logic signed [SCORE_W-1:0] term_c
);

  logic [TYPE_W-1:0]         ptype;
  logic                      black;
  logic                      valid;
  logic signed [SCORE_W-1:0] ext;

  // Read address depends only on the piece and square, never on rd_val
  always_comb begin
    ptype     = piece[TYPE_W-1:0];
    black     = piece[COLOR_BIT];
    valid     = (ptype != EMPTY) && (32'(ptype) <= NUM_TYPES);
    rd_type_c = valid ? (ptype - 3'd1) : 3'd0;
    rd_sq_c   = black ? (sq ^ SQ_MIRROR) : sq;
  end

  always_comb begin
    ext    = SCORE_W'(rd_val);
    term_c = '0;
    if (valid) begin
      term_c = black ? -ext : ext;
    end
  end

endmodule

// File: rtl/pst_eval_engine.sv
// Loadable multi-piece PST evaluator: latches a board on start, scans it
// SQ_PER_CYCLE squares per cycle and reports white-minus-black positional score.
module pst_eval_engine
  import pst_eval_engine_pkg::*;
#(
  parameter int unsigned NUM_TYPES    = 6,
  parameter int unsigned VAL_W        = 6,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned SQ_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  pst_eval_engine_if.slave  bus
);

  localparam int unsigned LAST_IDX = NUM_SQ - SQ_PER_CYCLE;

  state_e                    state_q, state_d;
  logic [BOARD_W-1:0]        board_q, board_d;
  logic [SQ_W-1:0]           idx_q, idx_d;
  logic signed [SCORE_W-1:0] acc_q, acc_d;
  logic signed [SCORE_W-1:0] score_q, score_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic signed [VAL_W-1:0]   tbl_q [NUM_TYPES][NUM_SQ];
  logic signed [VAL_W-1:0]   tbl_d [NUM_TYPES][NUM_SQ];

  logic [SQ_W-1:0]           lane_sq      [SQ_PER_CYCLE];
  logic [PIECE_W-1:0]        lane_piece   [SQ_PER_CYCLE];
  logic [TYPE_W-1:0]         lane_rd_type [SQ_PER_CYCLE];
  logic [SQ_W-1:0]           lane_rd_sq   [SQ_PER_CYCLE];
  logic signed [VAL_W-1:0]   lane_rd_val  [SQ_PER_CYCLE];
  logic signed [SCORE_W-1:0] lane_term    [SQ_PER_CYCLE];
  logic signed [SCORE_W-1:0] scan_sum_c;
  logic                      wr_ok_c;

  // Table writes only land while idle; a write in the start cycle is seen by that scan
  always_comb begin
    wr_ok_c = (state_q == IDLE) && bus.wr_en && (bus.wr_type != EMPTY) &&
              (32'(bus.wr_type) <= NUM_TYPES);
    tbl_d   = tbl_q;
    if (wr_ok_c) begin
      tbl_d[bus.wr_type - 3'd1][bus.wr_sq] = bus.wr_data;
    end
  end

  for (genvar k = 0; k < SQ_PER_CYCLE; k++) begin : g_lane
    assign lane_sq[k]     = idx_q + 6'(k);
    assign lane_piece[k]  = board_q[{lane_sq[k], 2'b00} +: PIECE_W];
    assign lane_rd_val[k] = tbl_q[lane_rd_type[k]][lane_rd_sq[k]];

    pst_square_term #(
      .NUM_TYPES (NUM_TYPES),
      .VAL_W     (VAL_W),
      .SCORE_W   (SCORE_W)
    ) u_term (
      .piece     (lane_piece[k]),
      .sq        (lane_sq[k]),
      .rd_type_c (lane_rd_type[k]),
      .rd_sq_c   (lane_rd_sq[k]),
      .rd_val    (lane_rd_val[k]),
      .term_c    (lane_term[k])
    );
  end

  always_comb begin
    scan_sum_c = '0;
    for (int k = 0; k < SQ_PER_CYCLE; k++) begin
      scan_sum_c = scan_sum_c + lane_term[k];
    end
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    score_d = score_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          board_d = bus.board;
          idx_d   = '0;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d = acc_q + scan_sum_c;
        idx_d = idx_q + 6'(SQ_PER_CYCLE);
        if (idx_q == 6'(LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        score_d = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      board_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      score_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int t = 0; t < NUM_TYPES; t++) begin
        for (int s = 0; s < NUM_SQ; s++) begin
          tbl_q[t][s] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl_q   <= tbl_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.score = score_q;

endmodule

// File: tb/tb_pst_eval_engine.sv
// Bench for pst_eval_engine: one-square-per-cycle and eight-square-per-cycle
// instances share stimulus and are checked every cycle against a table/queue model.
module tb_pst_eval_engine;
  import pst_eval_engine_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [255:0]      board;
  logic              start;
  logic              wr_en;
  logic [2:0]        wr_type;
  logic [5:0]        wr_sq;
  logic signed [5:0] wr_data;

  pst_eval_engine_if #(.VAL_W(6), .SCORE_W(16)) bus0 ();
  pst_eval_engine_if #(.VAL_W(6), .SCORE_W(16)) bus8 ();

  assign bus0.board = board;   assign bus8.board = board;
  assign bus0.start = start;   assign bus8.start = start;
  assign bus0.wr_en = wr_en;   assign bus8.wr_en = wr_en;
  assign bus0.wr_type = wr_type; assign bus8.wr_type = wr_type;
  assign bus0.wr_sq = wr_sq;   assign bus8.wr_sq = wr_sq;
  assign bus0.wr_data = wr_data; assign bus8.wr_data = wr_data;

  pst_eval_engine #(.NUM_TYPES(6), .VAL_W(6), .SCORE_W(16), .SQ_PER_CYCLE(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  pst_eval_engine #(.NUM_TYPES(6), .VAL_W(6), .SCORE_W(16), .SQ_PER_CYCLE(8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8));

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;

  // Model: per instance, tables plus a countdown of edges until the result appears
  int m_tbl [2][6][64];
  int m_rem [2];
  int m_pend [2];
  int m_score [2];
  bit m_done [2];
  int lat_edges [2] = '{65, 9};
  int acc_edge [2];
  int done_edge [2];
  int busy_cnt [2];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int eval_board(input int d, input logic [255:0] b);
    int sum = 0;
    for (int s = 0; s < 64; s++) begin
      logic [3:0] p;
      int t;
      p = b[s*4 +: 4];
      t = int'(p[2:0]);
      if (t >= 1 && t <= 6) begin
        if (p[3]) sum -= m_tbl[d][t-1][s ^ 56];
        else      sum += m_tbl[d][t-1][s];
      end
    end
    return sum;
  endfunction

  function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] code);
    logic [255:0] r;
    r = b;
    r[sq*4 +: 4] = code;
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_rem[d] = 0; m_score[d] = 0; m_done[d] = 1'b0;
        for (int t = 0; t < 6; t++)
          for (int s = 0; s < 64; s++) m_tbl[d][t][s] = 0;
      end else begin
        m_done[d] = 1'b0;
        if (m_rem[d] > 0) begin
          m_rem[d]--;
          if (m_rem[d] == 0) begin
            m_done[d] = 1'b1;
            m_score[d] = m_pend[d];
            done_edge[d] = cyc;
          end
        end else begin
          if (wr_en && wr_type >= 3'd1 && wr_type <= 3'd6)
            m_tbl[d][int'(wr_type) - 1][wr_sq] = int'(wr_data);
          if (start) begin
            m_pend[d] = eval_board(d, board);
            m_rem[d] = lat_edges[d];
            acc_edge[d] = cyc;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("busy0", bus0.busy, m_rem[0] > 0);
      chk("done0", bus0.done, m_done[0]);
      chk("score0", bus0.score, m_score[0]);
      chk("busy8", bus8.busy, m_rem[1] > 0);
      chk("done8", bus8.done, m_done[1]);
      chk("score8", bus8.score, m_score[1]);
      if (bus0.busy === 1'b1) busy_cnt[0]++;
      if (bus8.busy === 1'b1) busy_cnt[1]++;
    end
  end

  task automatic write_entry(input int t, input int sq, input int v);
    @(negedge clk);
    wr_en = 1'b1; wr_type = 3'(t); wr_sq = 6'(sq); wr_data = 6'(v);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_eval(input logic [255:0] b);
    @(negedge clk);
    board = b; start = 1'b1;
    busy_cnt[0] = 0; busy_cnt[1] = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int budget = 200;
    while ((m_rem[0] > 0 || m_rem[1] > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    asserts++;
    if (budget == 0) begin
      fails++;
      $display("FAIL %s_timeout: evaluation still busy after 200 cycles", nm);
    end
  endtask

  task automatic run_eval(input string nm, input logic [255:0] b, input int exp);
    start_eval(b);
    wait_idle(nm);
    chk({nm, "_dut0"}, bus0.score, exp);
    chk({nm, "_dut8"}, bus8.score, exp);
  endtask

  initial begin
    logic [255:0] b;
    logic [255:0] full;
    reset = 1'b1; board = '0; start = 1'b0;
    wr_en = 1'b0; wr_type = '0; wr_sq = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy0", bus0.busy, 0);
    chk("rst_done0", bus0.done, 0);
    chk("rst_score0", bus0.score, 0);
    chk("rst_score8", bus8.score, 0);

    // Empty board: zero score, busy 65 / 9 cycles, done 66 / 10 cycles after start
    run_eval("empty", '0, 0);
    chk("busy_cycles0", busy_cnt[0], 65);
    chk("busy_cycles8", busy_cnt[1], 9);
    chk("latency0", done_edge[0] - acc_edge[0] + 1, 66);
    chk("latency8", done_edge[1] - acc_edge[1] + 1, 10);

    write_entry(int'(QUEEN), 3, 5);
    b = put('0, 3, 4'h5);
    chk("model_wq", eval_board(0, b), 5);
    run_eval("white_queen", b, 5);
    b = put('0, 59, 4'hD);
    chk("model_bq", eval_board(0, b), -5);
    run_eval("black_queen", b, -5);
    b = put(put('0, 3, 4'h5), 59, 4'hD);
    run_eval("both_queens", b, 0);

    // Write in the same cycle as start is visible to that scan
    @(negedge clk);
    board = put('0, 8, 4'h1); start = 1'b1;
    wr_en = 1'b1; wr_type = 3'd1; wr_sq = 6'd8; wr_data = 6'sd9;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_idle("same_cycle_wr");
    chk("same_cycle_wr_dut0", bus0.score, 9);
    chk("same_cycle_wr_dut8", bus8.score, 9);

    // Every entry at the minimum value, 32 white pieces
    for (int t = 1; t <= 6; t++)
      for (int s = 0; s < 64; s++) write_entry(t, s, -32);
    full = '0;
    for (int s = 0; s < 32; s++) full = put(full, s, 4'((s % 6) + 1));
    chk("model_full", eval_board(0, full), -1024);
    run_eval("full_min", full, -1024);

    // start, write and board change mid-scan are all ignored
    start_eval(full);
    repeat (4) @(negedge clk);
    start = 1'b1; board = '0;
    wr_en = 1'b1; wr_type = 3'd1; wr_sq = 6'd0; wr_data = 6'sd31;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_idle("busy_ignore");
    chk("busy_ignore_dut0", bus0.score, -1024);
    chk("busy_ignore_dut8", bus8.score, -1024);
    run_eval("entry_kept", put('0, 0, 4'h1), -32);

    // Reset mid-scan aborts and clears tables
    write_entry(int'(KNIGHT), 10, 7);
    b = put('0, 10, 4'h2);
    run_eval("knight_pre", b, 7);
    start_eval(b);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy0", bus0.busy, 0);
    chk("abort_done0", bus0.done, 0);
    chk("abort_score0", bus0.score, 0);
    repeat (3) @(negedge clk);
    chk("abort_nodone0", bus0.done, 0);
    run_eval("knight_post", b, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
